// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - grant encoding and default widths shared by the VRAM arbiter files
package vram_arb_pkg;

    localparam int AW_DEF      = 14;
    localparam int DW_DEF      = 8;
    localparam int MAXWAIT_DEF = 15;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_DMA  = 2'd3
    } gnt_t;

endpackage

// File: rtl/vram_arb_pick.sv
// rtl/vram_arb_pick.sv - combinational priority selector for one RAM slot
module vram_arb_pick
    import vram_arb_pkg::*;
(
    input  logic vidPend,
    input  logic cpuPend,
    input  logic dmaPend,
    input  logic aged,
    output gnt_t gnt
);

    // Video always wins; an aged DMA request jumps ahead of the CPU.
    always_comb begin
        gnt = GNT_NONE;
        if (vidPend) begin
            gnt = GNT_VID;
        end else if (aged && dmaPend) begin
            gnt = GNT_DMA;
        end else if (cpuPend) begin
            gnt = GNT_CPU;
        end else if (dmaPend) begin
            gnt = GNT_DMA;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares one single-port video RAM between video fetch, CPU and loader DMA
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int DMA_MAXWAIT = MAXWAIT_DEF
) (
    input  logic          reset,
    input  logic          clock,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic [DW-1:0] vid_q,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_d,
    output logic [DW-1:0] cpu_q,
    output logic          cpu_ack,
    output logic          cpu_wait_n,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_a,
    input  logic [DW-1:0] dma_d,
    output logic          dma_ack,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q
);

    localparam logic [3:0] AGE_MAX = 4'(DMA_MAXWAIT);

    logic       cpuDone;
    logic       dmaDone;
    logic       cpuAckSeen;
    logic [3:0] age;
    logic       cpuPend;
    logic       dmaPend;
    logic       grantWe;
    gnt_t       gnt;
    gnt_t       s1Gnt;
    gnt_t       s2Gnt;
    logic       s1We;
    logic       s2We;

    assign cpuPend = cpu_req && !cpuDone;
    assign dmaPend = dma_req && !dmaDone;

    vram_arb_pick uPick (
        .vidPend (vid_req),
        .cpuPend (cpuPend),
        .dmaPend (dmaPend),
        .aged    (age == AGE_MAX),
        .gnt     (gnt)
    );

    assign grantWe    = (gnt == GNT_DMA) || ((gnt == GNT_CPU) && cpu_we);
    assign cpu_wait_n = !(cpu_req && !(cpuAckSeen || cpu_ack));

    // Handshake bookkeeping: a held request is serviced once, re-armed only after req drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpuDone    <= 1'b0;
            dmaDone    <= 1'b0;
            cpuAckSeen <= 1'b0;
            age        <= '0;
        end else begin
            if (gnt == GNT_CPU) begin
                cpuDone <= 1'b1;
            end else if (!cpu_req) begin
                cpuDone <= 1'b0;
            end
            if (gnt == GNT_DMA) begin
                dmaDone <= 1'b1;
            end else if (!dma_req) begin
                dmaDone <= 1'b0;
            end
            if (!cpu_req) begin
                cpuAckSeen <= 1'b0;
            end else if (cpu_ack) begin
                cpuAckSeen <= 1'b1;
            end
            if (!dma_req || (gnt == GNT_DMA)) begin
                age <= '0;
            end else if (dmaPend && (gnt == GNT_CPU) && (age != AGE_MAX)) begin
                age <= age + 4'd1;
            end
        end
    end

    // Slot pipeline: issue at the grant edge, RAM samples one edge later, result two edges later.
    // A write always lands one edge before any later slot's read samples, so no forwarding is needed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_a     <= '0;
            mem_d     <= '0;
            mem_we    <= 1'b0;
            s1Gnt     <= GNT_NONE;
            s2Gnt     <= GNT_NONE;
            s1We      <= 1'b0;
            s2We      <= 1'b0;
            vid_q     <= '0;
            vid_valid <= 1'b0;
            cpu_q     <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
        end else begin
            mem_we <= grantWe;
            unique case (gnt)
                GNT_VID: mem_a <= vid_a;
                GNT_CPU: begin
                    mem_a <= cpu_a;
                    mem_d <= cpu_d;
                end
                GNT_DMA: begin
                    mem_a <= dma_a;
                    mem_d <= dma_d;
                end
                default: ;
            endcase

            s1Gnt <= gnt;
            s1We  <= grantWe;
            s2Gnt <= s1Gnt;
            s2We  <= s1We;

            vid_valid <= (s2Gnt == GNT_VID);
            cpu_ack   <= (s2Gnt == GNT_CPU);
            dma_ack   <= (s2Gnt == GNT_DMA);
            if (s2Gnt == GNT_VID) begin
                vid_q <= mem_q;
            end
            if ((s2Gnt == GNT_CPU) && !s2We) begin
                cpu_q <= mem_q;
            end
        end
    end

endmodule
